// File: rtl/uart_tx_module.sv
// UART transmitter: sends one byte per request as a start bit, eight data bits
// LSB first, an optional parity bit and one or two stop bits. Every output is
// taken straight from a flop, so the line, busy and done are all one clock
// behind the FSM state that produces them.
module uart_tx_module #(
  parameter logic [12:0] BPS_T      = 13'd5208,  // clocks per line bit, 2..8191
  parameter logic        PARITY_EN  = 1'b0,      // 1 = parity bit after D7
  parameter logic        PARITY_ODD = 1'b0,      // 0 = even, 1 = odd parity
  parameter logic [1:0]  STOP_BITS  = 2'd1       // 1 or 2 stop bits
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       TX_En_Sig,
  input  logic [7:0] TX_Data,
  output logic       TX_Done_Sig,
  output logic       TX_Busy,
  output logic       TX_Pin_Out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;        // baud counter, 0..BPS_T-1
  logic [2:0]  bit_idx_q, bit_idx_d; // data bit index, reused as stop-bit count
  logic [7:0]  shift_q, shift_d;     // byte being sent, shifted right per bit
  logic        parity_q, parity_d;
  logic        pin_q, pin_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        bit_end;

  assign bit_end = (cnt_q == BPS_T - 13'd1);

  // Next-state, datapath and registered-output logic.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch can be inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (TX_En_Sig) begin
          shift_d  = TX_Data;
          parity_d = (^TX_Data) ^ PARITY_ODD;
          state_d  = S_START;
        end
      end
      S_START: begin
        cnt_d = bit_end ? 13'd0 : cnt_q + 13'd1;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        cnt_d = bit_end ? 13'd0 : cnt_q + 13'd1;
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        cnt_d = bit_end ? 13'd0 : cnt_q + 13'd1;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        cnt_d = bit_end ? 13'd0 : cnt_q + 13'd1;
        if (bit_end) begin
          if (bit_idx_q == {1'b0, STOP_BITS - 2'd1}) begin
            bit_idx_d = '0;
            state_d   = S_DONE;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        state_d   = S_IDLE;
      end
    endcase

    // Outputs follow the current state and land in flops one clock later.
    unique case (state_q)
      S_START:  pin_d = 1'b0;
      S_DATA:   pin_d = shift_q[0];
      S_PARITY: pin_d = parity_q;
      default:  pin_d = 1'b1;
    endcase
    busy_d = (state_q != S_IDLE);
    done_d = (state_q == S_DONE);
  end

  // State, datapath and output registers; reset aborts any frame in progress.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      pin_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      pin_q     <= pin_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign TX_Pin_Out  = pin_q;
  assign TX_Busy     = busy_q;
  assign TX_Done_Sig = done_q;

endmodule

// File: tb/tb_uart_tx_module.sv
// Bench for uart_tx_module: four fast instances (BPS_T=16) covering 8N1, even
// parity, odd parity and two stop bits, plus one instance at the default baud.
// Expected line waveforms are built from the frame format as a list of bits.
module tb_uart_tx_module;

  localparam int BPS = 16;

  logic       clk;
  logic       rst_n;
  logic [4:0] en;
  logic [7:0] data;
  wire  [4:0] pin;
  wire  [4:0] busy;
  wire  [4:0] done;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-instance frame format known to the reference model.
  int par_en    [5] = '{0, 1, 1, 0, 0};
  int par_odd   [5] = '{0, 0, 1, 0, 0};
  int stop_bits [5] = '{1, 1, 1, 2, 1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_module #(.BPS_T(13'd16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2'd1)) u_8n1 (
    .CLK(clk), .RSTn(rst_n), .TX_En_Sig(en[0]), .TX_Data(data),
    .TX_Done_Sig(done[0]), .TX_Busy(busy[0]), .TX_Pin_Out(pin[0]));
  uart_tx_module #(.BPS_T(13'd16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2'd1)) u_even (
    .CLK(clk), .RSTn(rst_n), .TX_En_Sig(en[1]), .TX_Data(data),
    .TX_Done_Sig(done[1]), .TX_Busy(busy[1]), .TX_Pin_Out(pin[1]));
  uart_tx_module #(.BPS_T(13'd16), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2'd1)) u_odd (
    .CLK(clk), .RSTn(rst_n), .TX_En_Sig(en[2]), .TX_Data(data),
    .TX_Done_Sig(done[2]), .TX_Busy(busy[2]), .TX_Pin_Out(pin[2]));
  uart_tx_module #(.BPS_T(13'd16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2'd2)) u_2stop (
    .CLK(clk), .RSTn(rst_n), .TX_En_Sig(en[3]), .TX_Data(data),
    .TX_Done_Sig(done[3]), .TX_Busy(busy[3]), .TX_Pin_Out(pin[3]));
  uart_tx_module u_dflt (
    .CLK(clk), .RSTn(rst_n), .TX_En_Sig(en[4]), .TX_Data(data),
    .TX_Done_Sig(done[4]), .TX_Busy(busy[4]), .TX_Pin_Out(pin[4]));

  // Present a request so that the next rising edge is the accept edge T0.
  task automatic start(input int idx, input logic [7:0] d);
    @(negedge clk);
    data    = d;
    en[idx] = 1'b1;
  endtask

  // Check one whole frame cycle by cycle, from T0 through the DONE cycle.
  // Cycle c is the value seen after edge T0+c. With chain=1 the request stays
  // high and nd is presented so the next frame is accepted at T0+N+2.
  task automatic run_frame(input int idx, input logic [7:0] d, input bit disturb,
                           input bit chain, input logic [7:0] nd);
    bit   bits[$];
    int   n;
    logic exp_pin, exp_busy, exp_done;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (par_en[idx] != 0) bits.push_back((^d) ^ par_odd[idx][0]);
    for (int i = 0; i < stop_bits[idx]; i++) bits.push_back(1'b1);
    n = bits.size() * BPS;
    @(posedge clk);
    for (int c = 0; c <= n + 1; c++) begin
      @(negedge clk);
      if (c == 0) begin
        exp_pin = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
      end else if (c <= n) begin
        exp_pin = bits[(c - 1) / BPS]; exp_busy = 1'b1; exp_done = 1'b0;
      end else begin
        exp_pin = 1'b1; exp_busy = 1'b1; exp_done = 1'b1;
      end
      n_checks += 3;
      if (pin[idx] !== exp_pin) begin
        n_fail++;
        $display("FAIL frame_pin u%0d d=%h c=%0d: got %b want %b", idx, d, c, pin[idx], exp_pin);
      end
      if (busy[idx] !== exp_busy) begin
        n_fail++;
        $display("FAIL frame_busy u%0d d=%h c=%0d: got %b want %b", idx, d, c, busy[idx], exp_busy);
      end
      if (done[idx] !== exp_done) begin
        n_fail++;
        $display("FAIL frame_done u%0d d=%h c=%0d: got %b want %b", idx, d, c, done[idx], exp_done);
      end
      if (c == n + 1) begin
        en[idx] = chain;
        if (chain) data = nd;
      end else if (disturb) begin
        en[idx] = 1'($urandom_range(0, 1));
        data    = 8'($urandom);
      end else begin
        en[idx] = chain;
      end
    end
  endtask

  // The cycle after DONE: back in idle with busy low.
  task automatic check_idle(input int idx);
    @(negedge clk);
    n_checks += 3;
    if (busy[idx] !== 1'b0) begin
      n_fail++; $display("FAIL idle_busy u%0d: got %b want 0", idx, busy[idx]);
    end
    if (pin[idx] !== 1'b1) begin
      n_fail++; $display("FAIL idle_pin u%0d: got %b want 1", idx, pin[idx]);
    end
    if (done[idx] !== 1'b0) begin
      n_fail++; $display("FAIL idle_done u%0d: got %b want 0", idx, done[idx]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = '0;
    data  = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_checks += 3;
      if (pin[i] !== 1'b1) begin
        n_fail++; $display("FAIL reset_pin u%0d: got %b want 1", i, pin[i]);
      end
      if (busy[i] !== 1'b0) begin
        n_fail++; $display("FAIL reset_busy u%0d: got %b want 0", i, busy[i]);
      end
      if (done[i] !== 1'b0) begin
        n_fail++; $display("FAIL reset_done u%0d: got %b want 0", i, done[i]);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_directed();
    start(0, 8'h55); run_frame(0, 8'h55, 1'b0, 1'b0, 8'h00); check_idle(0);
    start(1, 8'h07); run_frame(1, 8'h07, 1'b0, 1'b0, 8'h00); check_idle(1);
    start(2, 8'h07); run_frame(2, 8'h07, 1'b0, 1'b0, 8'h00); check_idle(2);
    start(3, 8'hFF); run_frame(3, 8'hFF, 1'b0, 1'b0, 8'h00); check_idle(3);
  endtask

  task automatic test_back_to_back();
    start(0, 8'hA3);
    run_frame(0, 8'hA3, 1'b0, 1'b1, 8'h3C);
    run_frame(0, 8'h3C, 1'b0, 1'b0, 8'h00);
    check_idle(0);
  endtask

  task automatic test_ignore_midframe();
    logic [7:0] d;
    for (int k = 0; k < 3; k++) begin
      d = 8'($urandom);
      start(k, d);
      run_frame(k, d, 1'b1, 1'b0, 8'h00);
      check_idle(k);
    end
  endtask

  task automatic test_random();
    int         idx;
    logic [7:0] d;
    for (int k = 0; k < 6; k++) begin
      idx = $urandom_range(0, 3);
      d   = 8'($urandom);
      start(idx, d);
      run_frame(idx, d, 1'b0, 1'b0, 8'h00);
      check_idle(idx);
    end
  endtask

  // Reset in the middle of D3 aborts the frame with no done; the next request
  // sends a clean frame.
  task automatic test_reset_abort();
    logic [7:0] d;
    start(0, 8'h3C);
    @(posedge clk);
    en[0] = 1'b0;
    repeat (72) @(negedge clk);
    n_checks++;
    if (pin[0] !== 1'b1) begin  // D3 of 0x3C is 1
      n_fail++; $display("FAIL abort_d3 u0: got %b want 1", pin[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (pin[0] !== 1'b1) begin
      n_fail++; $display("FAIL abort_pin u0: got %b want 1", pin[0]);
    end
    if (busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL abort_busy u0: got %b want 0", busy[0]);
    end
    if (done[0] !== 1'b0) begin
      n_fail++; $display("FAIL abort_done u0: got %b want 0", done[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      n_checks++;
      if (done[0] !== 1'b0 || pin[0] !== 1'b1 || busy[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet u0 c=%0d: got done=%b pin=%b busy=%b want 0/1/0",
                 c, done[0], pin[0], busy[0]);
      end
    end
    d = 8'($urandom);
    start(0, d);
    run_frame(0, d, 1'b0, 1'b0, 8'h00);
    check_idle(0);
  endtask

  // Default 5208-clock bit: spot-check bit edges and the DONE cycle of 0x01.
  task automatic test_default_baud();
    int   first_done;
    logic exp_pin;
    bit   spot;
    first_done = -1;
    start(4, 8'h01);
    @(posedge clk);
    for (int c = 0; c <= 52090; c++) begin
      @(negedge clk);
      if (c == 0) en[4] = 1'b0;
      spot = 1'b1;
      if (c == 1 || c == 5208 || c == 10417)      exp_pin = 1'b0;
      else if (c == 5209 || c == 10416)           exp_pin = 1'b1;
      else                                        spot = 1'b0;
      if (spot) begin
        n_checks++;
        if (pin[4] !== exp_pin) begin
          n_fail++; $display("FAIL dflt_pin c=%0d: got %b want %b", c, pin[4], exp_pin);
        end
      end
      if (done[4] === 1'b1 && first_done < 0) first_done = c;
    end
    n_checks++;
    if (first_done != 52081) begin
      n_fail++; $display("FAIL dflt_done_cycle: got %0d want 52081", first_done);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignore_midframe();
    test_random();
    test_reset_abort();
    test_default_baud();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
